keypad_encoder: RTL
===================

// Module: keypad_encoder
// PURPOSE
//  Front end of the synthesizer datapath: turns the raw 17-bit keypad vector into note/control state.
//  Synchronizes and debounces the keypad, then tracks octave and mode from button edges.
//  Priority-encodes the 13 note keys into a tone divider for the downstream PWM tone generator.
//  Emits a 1-cycle strobe whenever the divider changes.
// PARAMETERS
//  SYNC_STAGES      2      flops in input synchronizer chain (>=2)
//  DEBOUNCE_CYCLES  1000   cycles the synced vector must be stable before it is accepted (>=2)
//  OCT_RESET        2      octave after reset (0..4)
// PORTS
//  clk       in   1   system clock, 10 MHz
//  nrst      in   1   asynchronous active-low reset
//  keypad    in   17  raw {oct_up[16], oct_down[15], mode[14], goof[13], keys[12:0]}; 0 when chip deselected
//  divider   out  18  clk cycles per tone period; 0 = silence
//  strobe    out  1   1-cycle pulse, same cycle divider takes a new value
//  mode      out  2   current voice mode
//  octave    out  3   current octave, 0..4
//  goof      out  1   debounced goof key (0 when GOOF_EN undefined)
// BEHAVIOUR
//  Reset: divider=0, strobe=0, mode=0, octave=OCT_RESET, goof=0; sync chain, debounced vector, counter all 0.
//  Sync: keypad passes SYNC_STAGES flops -> s.
//  Debounce (shared counter):
//   - s != s_prev: cnt <= 0.
//   - Else if cnt == DEBOUNCE_CYCLES-1: deb <= s, cnt holds.
//   - Else cnt++.
//  Edges: rise = deb & ~deb_d (deb_d = deb delayed one cycle); only bits 16,15,14 are used.
//  Octave: rise[16] alone -> +1, saturate at 4. rise[15] alone -> -1, saturate at 0.
//   Both rising in the same cycle -> no change.
//  Mode: rise[14] -> mode+1, wraps 3->0.
//  Note select: lowest set index of deb[12:0] wins.
//   idx k -> nom = NOTE_DIV[k] >> octave; no key -> nom = 0.
//  Output: divider <= nom each cycle; strobe <= (nom != divider). Both registered.
//  Latency: keypad edge to divider/strobe = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (+1 for octave/mode-driven changes).
//  Octave change while key held: divider re-evaluates next cycle and strobes.
//  Release of all keys: divider -> 0 with strobe.
//  Bounce shorter than DEBOUNCE_CYCLES: no change to any output.
//  nrst asserted mid-note: all outputs return to reset values immediately (async).
//  Arithmetic: shift is a logical right shift of an 18-bit value; no overflow possible (octave 0 is the largest divider).
// CONFIGURATION
//  KEYPAD_GOOF_EN defined:
//   - 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01), free-running from reset.
//   - While deb[13]=1 and a note is active: nom = (NOTE_DIV[k]>>octave) + {10'b0, lfsr}, lfsr sampled only when idx/octave changes.
//   - goof = deb[13].
//  KEYPAD_GOOF_EN undefined: bit 13 ignored, goof tied 0, no LFSR.
// STRUCTURE
//  synth_pkg:
//   - NOTE_DIV[0:12]: 18-bit, round(10e6/f) for C2..C3; NOTE_DIV[0]=152890, NOTE_DIV[12]=76445.
//   - OCT_MAX=4, DIV_W=18, KEY_W=13, KP_W=17.
//   - Bit-index constants KP_OCT_UP/KP_OCT_DN/KP_MODE/KP_GOOF.
//  Sub-module keypad_debouncer (sync chain + shared-counter debounce, param width).
//   Encoder, octave/mode and output regs stay in this module.
// TESTING (bench uses DEBOUNCE_CYCLES=8)
//  1. Reset, press keys[0] clean.
//     -> after 2+8+1 cycles divider=38222 (152890>>2), one strobe; release -> divider=0, one strobe.
//  2. Hold keys[0] and keys[5].
//     -> divider tracks key 0; release key 0 -> divider=NOTE_DIV[5]>>2, strobe.
//  3. Hold keys[12], press oct_up 3 times.
//     -> octave 3,4,4 (saturate); divider=76445>>4=4777.
//  4. Toggle mode key 4 times.
//     -> mode 1,2,3,0.
//     Bounce oct_down with pulses of 5 cycles -> no octave change.
//  5. Press oct_up and oct_down same cycle -> octave stays 2.
//     Assert nrst mid-note -> divider=0, octave=2 at once.
//  6. (KEYPAD_GOOF_EN) hold goof + keys[0].
//     -> divider in 38222..38477, goof=1.
//     Undefined: divider=38222, goof=0.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants, note divider table and note selection helper
package synth_pkg;

    localparam int OCT_MAX = 4;
    localparam int DIV_W   = 18;
    localparam int KEY_W   = 13;
    localparam int KP_W    = 17;

    localparam int KP_OCT_UP = 16;
    localparam int KP_OCT_DN = 15;
    localparam int KP_MODE   = 14;
    localparam int KP_GOOF   = 13;

    typedef logic [DIV_W-1:0] div_t;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } mode_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } note_sel_t;

    // Clock cycles (10 MHz) per period for C2..C3 at octave 0.
    localparam div_t NOTE_DIV [0:KEY_W-1] = '{
        18'd152890, 18'd144309, 18'd136210, 18'd128565,
        18'd121349, 18'd114538, 18'd108110, 18'd102042,
        18'd96315,  18'd90909,  18'd85807,  18'd80991,
        18'd76445
    };

    // Lowest pressed key index wins; valid=0 when no key is down.
    function automatic note_sel_t lowest_set(input logic [KEY_W-1:0] keys);
        note_sel_t r;
        r = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (keys[i]) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// rtl/keypad_encoder_if.sv - keypad input and note/control output bundle
interface keypad_encoder_if;
    import synth_pkg::*;

    logic [KP_W-1:0]  keypad;
    logic [DIV_W-1:0] divider;
    logic             strobe;
    logic [1:0]       mode;
    logic [2:0]       octave;
    logic             goof;

    modport master (
        output keypad,
        input  divider, strobe, mode, octave, goof
    );

    modport slave (
        input  keypad,
        output divider, strobe, mode, octave, goof
    );
endinterface

// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - synchronizer chain plus shared-counter debounce of a bit vector
module keypad_debouncer #(
    parameter int WIDTH           = 17,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] deb_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s_prev_q;
    logic [WIDTH-1:0] deb_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] s;

    assign s     = sync_q[SYNC_STAGES-1];
    assign deb_o = deb_q;

    // Any change anywhere in the vector restarts the single shared stability counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            s_prev_q <= '0;
            deb_q    <= '0;
            cnt_q    <= '0;
        end else begin
            sync_q[0] <= raw_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            s_prev_q <= s;
            if (s != s_prev_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_q <= s;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - keypad front end: debounce, octave/mode tracking, note divider (optional KEYPAD_GOOF_EN)
module keypad_encoder
    import synth_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int OCT_RESET       = 2
) (
    input  logic              clk,
    input  logic              nrst,
    keypad_encoder_if.slave   kp
);
    logic [KP_W-1:0]  deb;
    logic [KP_W-1:0]  deb_d_q;
    logic             rise_up, rise_dn, rise_mode;
    logic [2:0]       octave_q, octave_d;
    mode_t            mode_q, mode_d;
    div_t             divider_q;
    logic             strobe_q;
    note_sel_t        sel;
    div_t             base;
    div_t             nom;
    logic             goof;

    keypad_debouncer #(
        .WIDTH           (KP_W),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .nrst  (nrst),
        .raw_i (kp.keypad),
        .deb_o (deb)
    );

    assign rise_up   = deb[KP_OCT_UP] & ~deb_d_q[KP_OCT_UP];
    assign rise_dn   = deb[KP_OCT_DN] & ~deb_d_q[KP_OCT_DN];
    assign rise_mode = deb[KP_MODE]   & ~deb_d_q[KP_MODE];

    // Octave steps saturate at both ends; simultaneous up/down presses cancel.
    always_comb begin
        octave_d = octave_q;
        if (rise_up && !rise_dn && octave_q != 3'(OCT_MAX)) begin
            octave_d = octave_q + 3'd1;
        end else if (rise_dn && !rise_up && octave_q != 3'd0) begin
            octave_d = octave_q - 3'd1;
        end
        mode_d = rise_mode ? mode_t'(mode_q + 2'd1) : mode_q;
    end

`ifdef KEYPAD_GOOF_EN
    logic [7:0] lfsr_q;
    logic [7:0] jitter_q;
    logic [3:0] last_idx_q;
    logic [2:0] last_oct_q;
    logic       last_valid_q;
    logic       sel_changed;
    logic [7:0] jitter;

    assign sel_changed = !last_valid_q || (sel.idx != last_idx_q) || (octave_q != last_oct_q);
    assign jitter      = sel_changed ? lfsr_q : jitter_q;
    assign goof        = deb[KP_GOOF];

    // Free-running x^8+x^6+x^5+x^4+1 LFSR; jitter is latched only when the note or octave changes.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lfsr_q       <= 8'h01;
            jitter_q     <= '0;
            last_idx_q   <= '0;
            last_oct_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            lfsr_q       <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            last_idx_q   <= sel.idx;
            last_oct_q   <= octave_q;
            last_valid_q <= sel.valid;
            if (sel.valid && sel_changed) jitter_q <= lfsr_q;
        end
    end
`else
    logic unused_goof_bit;
    assign unused_goof_bit = deb[KP_GOOF];
    assign goof            = 1'b0;
`endif

    // Lowest pressed key selects the note; octave halves the period per step.
    always_comb begin
        sel  = lowest_set(deb[KEY_W-1:0]);
        base = sel.valid ? (NOTE_DIV[sel.idx] >> octave_q) : '0;
        nom  = base;
`ifdef KEYPAD_GOOF_EN
        if (sel.valid && deb[KP_GOOF]) nom = base + {10'b0, jitter};
`endif
    end

    // Control state and registered outputs; strobe marks the cycle the divider changes.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            deb_d_q   <= '0;
            octave_q  <= 3'(OCT_RESET);
            mode_q    <= MODE_0;
            divider_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            deb_d_q   <= deb;
            octave_q  <= octave_d;
            mode_q    <= mode_d;
            divider_q <= nom;
            strobe_q  <= (nom != divider_q);
        end
    end

    assign kp.divider = divider_q;
    assign kp.strobe  = strobe_q;
    assign kp.mode    = mode_q;
    assign kp.octave  = octave_q;
    assign kp.goof    = goof;
endmodule
